// File: rtl/banked_regfile_pkg.sv
// banked_regfile_pkg: shared constants and width helper for the banked
// register file (link register indices, default shadow mask, clog2).
package banked_regfile_pkg;

   localparam int unsigned LINK_LO = 2;
   localparam int unsigned LINK_HI = 3;
   localparam int unsigned DEF_SHADOW_MASK = 32'hC;

   function automatic int unsigned rf_clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/regbank_slice.sv
// regbank_slice: storage for one register address, 1 or NBANKS copies.
// Ports: clk, nclr, depth, wr/wd (bank[depth]), ld/ld_bank/ld_d, q.
module regbank_slice
   import banked_regfile_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NBANKS = 2,
   parameter int unsigned DW = 1,
   parameter bit BANKED = 1'b1
) (
   input  logic             clk,
   input  logic             nclr,
   input  logic [DW-1:0]    depth,
   input  logic             wr,
   input  logic [WIDTH-1:0] wd,
   input  logic             ld,
   input  logic [DW-1:0]    ld_bank,
   input  logic [WIDTH-1:0] ld_d,
   output logic [WIDTH-1:0] q
);

   if (BANKED) begin : g_banked
      logic [WIDTH-1:0] mem [NBANKS];

      // The link load wins over a plain write to the same copy.
      always_ff @(posedge clk or negedge nclr) begin
         if (!nclr) begin
            for (int b = 0; b < int'(NBANKS); b++)
               mem[b] <= '0;
         end else begin
            for (int b = 0; b < int'(NBANKS); b++) begin
               if (ld && ld_bank == DW'(b))
                  mem[b] <= ld_d;
               else if (wr && depth == DW'(b))
                  mem[b] <= wd;
            end
         end
      end

      assign q = mem[depth];
   end else begin : g_flat
      logic [WIDTH-1:0] r;
      logic unused_sel;

      assign unused_sel = ^{depth, ld_bank};

      always_ff @(posedge clk or negedge nclr) begin
         if (!nclr)
            r <= '0;
         else if (ld)
            r <= ld_d;
         else if (wr)
            r <= wd;
      end

      assign q = r;
   end

endmodule

// File: rtl/banked_regfile.sv
// banked_regfile: register file with NBANKS interrupt shadow banks.
// Ports: write port, two comb read ports, int_enter/int_ret, ret_ra, depth, fault.
module banked_regfile
   import banked_regfile_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREGS = 4,
   parameter int unsigned NBANKS = 2,
   parameter int unsigned SHADOW_MASK = DEF_SHADOW_MASK,
   parameter int unsigned RSW = rf_clog2(NREGS),
   parameter int unsigned DW = rf_clog2(NBANKS)
) (
   input  logic               clk,
   input  logic               nclr,
   input  logic               we,
   input  logic [RSW-1:0]     wa,
   input  logic [WIDTH-1:0]   wd,
   input  logic [RSW-1:0]     ra_a,
   input  logic [RSW-1:0]     ra_b,
   output logic [WIDTH-1:0]   rd_a,
   output logic [WIDTH-1:0]   rd_b,
   input  logic               int_enter,
   input  logic               int_ret,
   input  logic [2*WIDTH-1:0] int_ra,
   output logic [2*WIDTH-1:0] ret_ra,
   output logic [DW-1:0]      depth,
   output logic               fault
);

   localparam logic [DW-1:0] DMAX = DW'(NBANKS - 1);

   logic             at_top;
   logic             at_bot;
   logic             tail;
   logic             enter;
   logic             leave;
   logic             ld_en;
   logic [DW-1:0]    ld_bank;
   logic [WIDTH-1:0] q [NREGS];

   assign at_top = (depth == DMAX);
   assign at_bot = (depth == '0);

   // Tail-chain only when nested; at depth 0 both strobes act as entry.
   assign tail  = int_enter & int_ret & ~at_bot;
   assign enter = int_enter & ~tail;
   assign leave = int_ret & ~int_enter;

   // Entry captures into the next bank; tail-chain reloads the current one.
   assign ld_en   = tail | (enter & ~at_top);
   assign ld_bank = tail ? depth : depth + DW'(1);

   always_ff @(posedge clk or negedge nclr) begin
      if (!nclr) begin
         depth <= '0;
         fault <= 1'b0;
      end else if (enter) begin
         if (at_top)
            fault <= 1'b1;
         else
            depth <= depth + DW'(1);
      end else if (leave) begin
         if (at_bot)
            fault <= 1'b1;
         else
            depth <= depth - DW'(1);
      end
   end

   for (genvar i = 0; i < int'(NREGS); i++) begin : g_reg
      localparam bit IS_LINK = (i == int'(LINK_LO)) || (i == int'(LINK_HI));
      localparam bit BANKED  = IS_LINK || (((SHADOW_MASK >> i) & 1) != 0);

      logic [WIDTH-1:0] ld_d;

      if (i == int'(LINK_HI)) begin : g_hi
         assign ld_d = int_ra[2*WIDTH-1:WIDTH];
      end else begin : g_lo
         assign ld_d = int_ra[WIDTH-1:0];
      end

      regbank_slice #(
         .WIDTH  (WIDTH),
         .NBANKS (NBANKS),
         .DW     (DW),
         .BANKED (BANKED)
      ) u_slice (
         .clk     (clk),
         .nclr    (nclr),
         .depth   (depth),
         .wr      (we && (wa == RSW'(i))),
         .wd      (wd),
         .ld      (ld_en && IS_LINK),
         .ld_bank (ld_bank),
         .ld_d    (ld_d),
         .q       (q[i])
      );
   end

   assign rd_a   = q[ra_a];
   assign rd_b   = q[ra_b];
   assign ret_ra = {q[LINK_HI], q[LINK_LO]};

endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: scoreboard bench for banked_regfile against an
// array-of-banks reference model (WIDTH=16, NREGS=8, NBANKS=4).
module tb_banked_regfile;

   localparam int W   = 16;
   localparam int NR  = 8;
   localparam int NB  = 4;
   localparam int RSW = 3;
   localparam int DW  = 2;
   localparam int unsigned SM = 32'h24;

   logic           clk = 1'b0;
   logic           nclr = 1'b0;
   logic           we = 1'b0;
   logic [RSW-1:0] wa = '0;
   logic [W-1:0]   wd = '0;
   logic [RSW-1:0] ra_a = '0;
   logic [RSW-1:0] ra_b = '0;
   logic [W-1:0]   rd_a;
   logic [W-1:0]   rd_b;
   logic           int_enter = 1'b0;
   logic           int_ret = 1'b0;
   logic [2*W-1:0] int_ra = '0;
   logic [2*W-1:0] ret_ra;
   logic [DW-1:0]  depth;
   logic           fault;

   always #5 clk = ~clk;

   banked_regfile #(
      .WIDTH       (W),
      .NREGS       (NR),
      .NBANKS      (NB),
      .SHADOW_MASK (SM)
   ) dut (
      .clk       (clk),
      .nclr      (nclr),
      .we        (we),
      .wa        (wa),
      .wd        (wd),
      .ra_a      (ra_a),
      .ra_b      (ra_b),
      .rd_a      (rd_a),
      .rd_b      (rd_b),
      .int_enter (int_enter),
      .int_ret   (int_ret),
      .int_ra    (int_ra),
      .ret_ra    (ret_ra),
      .depth     (depth),
      .fault     (fault)
   );

   // Reference model: every register has NB slots; unbanked ones use slot 0.
   logic [W-1:0] m [NB][NR];
   int md;
   bit mf;

   function automatic bit banked(input int r);
      return (((SM >> r) & 1) != 0) || r == 2 || r == 3;
   endfunction

   function automatic int slot(input int r, input int b);
      return banked(r) ? b : 0;
   endfunction

   function automatic logic [W-1:0] m_rd(input int r);
      return m[slot(r, md)][r];
   endfunction

   task automatic m_reset();
      for (int b = 0; b < NB; b++)
         for (int r = 0; r < NR; r++)
            m[b][r] = '0;
      md = 0;
      mf = 1'b0;
   endtask

   task automatic m_update(input bit w, input int a, input logic [W-1:0] d,
                           input bit ie, input bit ir,
                           input logic [2*W-1:0] ira);
      int nd;
      nd = md;
      if (w) m[slot(a, md)][a] = d;
      if (ie && ir && md > 0) begin
         m[md][2] = ira[W-1:0];
         m[md][3] = ira[2*W-1:W];
      end else if (ie) begin
         if (md < NB - 1) begin
            nd = md + 1;
            m[nd][2] = ira[W-1:0];
            m[nd][3] = ira[2*W-1:W];
         end else begin
            mf = 1'b1;
         end
      end else if (ir) begin
         if (md > 0) nd = md - 1;
         else mf = 1'b1;
      end
      md = nd;
   endtask

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] r;
      logic [DW-1:0]  d;
      logic           f;
      string          tag;
   } exp_t;

   exp_t sbq[$];
   int n_cmp = 0;
   int n_bad = 0;
   bit drain_to = 1'b0;
   bit drain_rep = 1'b0;

   function automatic exp_t expect_now(input int qa, input int qb,
                                       input string tag);
      exp_t e;
      e.a = m_rd(qa);
      e.b = m_rd(qb);
      e.r = {m[md][3], m[md][2]};
      e.d = DW'(md);
      e.f = mf;
      e.tag = tag;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_cmp++;
         if (rd_a !== e.a || rd_b !== e.b || ret_ra !== e.r ||
             depth !== e.d || fault !== e.f) begin
            n_bad++;
            $display("FAIL %s: got rd_a=%h rd_b=%h ret_ra=%h depth=%0d fault=%b, want rd_a=%h rd_b=%h ret_ra=%h depth=%0d fault=%b",
                     e.tag, rd_a, rd_b, ret_ra, depth, fault,
                     e.a, e.b, e.r, e.d, e.f);
         end
      end
      if (drain_to && !drain_rep) begin
         drain_rep = 1'b1;
         n_cmp++;
         n_bad++;
         $display("FAIL drain: queue holds %0d, want 0", sbq.size());
      end
   end

   // Inputs are applied just after a rising edge; the expectation for the
   // current (pre-edge) state is queued and checked on the falling edge.
   task automatic step(input bit w, input int a, input logic [W-1:0] d,
                       input bit ie, input bit ir,
                       input logic [2*W-1:0] ira,
                       input int qa, input int qb, input string tag);
      we = w;
      wa = RSW'(a);
      wd = d;
      int_enter = ie;
      int_ret = ir;
      int_ra = ira;
      ra_a = RSW'(qa);
      ra_b = RSW'(qb);
      sbq.push_back(expect_now(qa, qb, tag));
      @(posedge clk);
      m_update(w, a, d, ie, ir, ira);
      #1;
   endtask

   task automatic idle(input int qa, input int qb, input string tag);
      step(1'b0, 0, '0, 1'b0, 1'b0, '0, qa, qb, tag);
   endtask

   task automatic hard_reset(input int qa, input int qb, input string tag);
      we = 1'b0;
      int_enter = 1'b0;
      int_ret = 1'b0;
      ra_a = RSW'(qa);
      ra_b = RSW'(qb);
      nclr = 1'b0;
      m_reset();
      sbq.push_back(expect_now(qa, qb, tag));
      @(posedge clk);
      #1;
      nclr = 1'b1;
   endtask

   initial begin
      m_reset();
      @(posedge clk);
      #1;
      hard_reset(0, 1, "reset");

      step(1'b1, 1, 16'h5A5A, 1'b0, 1'b0, '0, 1, 2, "w_r1");
      step(1'b0, 0, '0, 1'b1, 1'b0, 32'hBEEF_0001, 1, 2, "enter_pre_rst");
      hard_reset(1, 2, "mid_reset");
      idle(1, 2, "post_reset");

      step(1'b1, 2, 16'h1111, 1'b0, 1'b0, '0, 2, 1, "w_r2_b0");
      step(1'b1, 1, 16'h4242, 1'b0, 1'b0, '0, 2, 1, "w_r1_b0");
      step(1'b0, 0, '0, 1'b1, 1'b0, 32'hBEEF_CAFE, 2, 1, "enter_iso");
      step(1'b1, 2, 16'h7777, 1'b0, 1'b0, '0, 2, 1, "w_r2_b1");
      step(1'b0, 0, '0, 1'b0, 1'b1, '0, 2, 1, "ret_iso");
      idle(2, 1, "after_ret");

      step(1'b0, 0, '0, 1'b1, 1'b0, 32'h0000_1111, 2, 3, "nest1");
      step(1'b1, 5, 16'hB1B1, 1'b1, 1'b0, 32'h0000_2222, 5, 4, "nest2");
      step(1'b1, 4, 16'hC4C4, 1'b1, 1'b0, 32'h0000_3333, 5, 4, "nest3");
      idle(5, 4, "depth3");
      step(1'b0, 0, '0, 1'b1, 1'b0, 32'hDEAD_DEAD, 2, 3, "overflow");
      idle(2, 3, "after_ovf");
      step(1'b0, 0, '0, 1'b0, 1'b1, '0, 2, 3, "ret3");
      step(1'b0, 0, '0, 1'b0, 1'b1, '0, 5, 4, "ret2");
      step(1'b0, 0, '0, 1'b0, 1'b1, '0, 5, 4, "ret1");
      idle(2, 3, "depth0");
      hard_reset(2, 3, "reset2");
      step(1'b0, 0, '0, 1'b0, 1'b1, '0, 2, 3, "underflow");
      idle(2, 3, "after_unf");
      hard_reset(2, 3, "reset3");

      step(1'b0, 0, '0, 1'b1, 1'b0, 32'hAAAA_BBBB, 3, 2, "enter_tc");
      step(1'b1, 3, 16'hFFFF, 1'b1, 1'b1, 32'h1234_5678, 3, 2, "tail");
      idle(3, 2, "tail_chk");
      step(1'b0, 0, '0, 1'b0, 1'b1, '0, 3, 2, "ret_tc");

      step(1'b1, 3, 16'hAAAA, 1'b1, 1'b0, 32'h5566_7788, 3, 2, "enter_w");
      idle(3, 2, "bank1_r3");
      step(1'b0, 0, '0, 1'b0, 1'b1, '0, 3, 2, "ret_w");
      idle(3, 2, "bank0_r3");

      for (int i = 0; i < 1500; i++) begin
         if (i == 750) begin
            hard_reset(int'($urandom_range(0, NR - 1)),
                       int'($urandom_range(0, NR - 1)), "rand_reset");
         end else begin
            step(1'($urandom_range(0, 1)),
                 int'($urandom_range(0, NR - 1)),
                 W'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 $urandom,
                 int'($urandom_range(0, NR - 1)),
                 int'($urandom_range(0, NR - 1)),
                 "random");
         end
      end

      we = 1'b0;
      int_enter = 1'b0;
      int_ret = 1'b0;
      for (int k = 0; k < 20 && sbq.size() > 0; k++)
         @(posedge clk);
      if (sbq.size() > 0) begin
         drain_to = 1'b1;
         @(posedge clk);
         @(posedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
